// File: rtl/cafe_temporizador.sv
// Timeout scheduler for the coffee-machine FSM: restarts a per-state seconds
// timer on every state entry and emits one-cycle TIMER / TIMER_2S expiry pulses.
module cafe_temporizador #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CNT_W         = 8,
    parameter int T_ESCOLHA     = 10,
    parameter int T_PAGAMENTO   = 30,
    parameter int T_ERRO_SENSOR = 3,
    parameter int T_ERRO_VALOR  = 3,
    parameter int T_PRESS       = 2,
    parameter int T_AQUEC       = 20,
    parameter int T_PRONTO      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ESTADO,
    input  logic             PAUSA,
    output logic             TIMER,
    output logic             TIMER_2S,
    output logic             ATIVO,
    output logic [CNT_W-1:0] SEGUNDOS_REST
);

    typedef enum logic [2:0] {
        ESPERANDO      = 3'b000,
        ESCOLHENDO     = 3'b001,
        PAGAMENTO      = 3'b010,
        ERRO_SENSOR    = 3'b011,
        ERRO_VALOR     = 3'b100,
        PRESSURIZACAO  = 3'b101,
        AQUECIMENTO    = 3'b110,
        PRONTO         = 3'b111
    } estado_t;

    localparam int                PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0]  PRESC_MAX = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0]  SEG_UM    = CNT_W'(1);

    estado_t          r_estado_ant;
    logic [PRE_W-1:0] r_presc;
    logic [CNT_W-1:0] r_seg;
    logic             r_ativo;
    logic             r_timer;
    logic             r_timer_2s;

    logic             w_entrada;
    logic             w_conta;
    logic             w_wrap;
    logic [CNT_W-1:0] w_t_novo;

    function automatic logic [CNT_W-1:0] timeout_de(input estado_t est);
        logic [CNT_W-1:0] t;
        t = '0;
        case (est)
            ESCOLHENDO:    t = CNT_W'(T_ESCOLHA);
            PAGAMENTO:     t = CNT_W'(T_PAGAMENTO);
            ERRO_SENSOR:   t = CNT_W'(T_ERRO_SENSOR);
            ERRO_VALOR:    t = CNT_W'(T_ERRO_VALOR);
            PRESSURIZACAO: t = CNT_W'(T_PRESS);
            AQUECIMENTO:   t = CNT_W'(T_AQUEC);
            PRONTO:        t = CNT_W'(T_PRONTO);
            default:       t = '0;
        endcase
        return t;
    endfunction

    assign w_entrada = (estado_t'(ESTADO) != r_estado_ant);
    assign w_conta   = r_ativo && !PAUSA;
    assign w_wrap    = w_conta && (r_presc == PRESC_MAX);
    assign w_t_novo  = timeout_de(estado_t'(ESTADO));

    // Entry takes priority over counting, so a state change on the expiry edge
    // reloads the timer and suppresses the old state's pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado_ant <= ESPERANDO;
            r_presc      <= '0;
            r_seg        <= '0;
            r_ativo      <= 1'b0;
            r_timer      <= 1'b0;
            r_timer_2s   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            r_estado_ant <= estado_t'(ESTADO);
            r_timer      <= 1'b0;
            r_timer_2s   <= 1'b0;
            if (w_entrada) begin
                r_presc <= '0;
                r_seg   <= w_t_novo;
                r_ativo <= (w_t_novo != '0);
            end else if (w_wrap) begin
                r_presc <= '0;
                if (r_seg != '0) begin
                    r_seg <= r_seg - SEG_UM;
                end
                if (r_seg == SEG_UM) begin
                    r_ativo <= 1'b0;
                    if (r_estado_ant == PRESSURIZACAO) begin
                        r_timer_2s <= 1'b1;
                    end else begin
                        r_timer <= 1'b1;
                    end
                end
            end else if (w_conta) begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    assign TIMER         = r_timer;
    assign TIMER_2S      = r_timer_2s;
    assign ATIVO         = r_ativo;
    assign SEGUNDOS_REST = r_seg;

endmodule
